// File: rtl/uart_rx_unit.sv
// -----------------------------------------------------------------------------
// uart_rx_unit
// Receive front-end of the memory-mapped UART. Oversamples the asynchronous
// Rx line, decodes 8N1 frames (LSB first) and holds the last good byte with a
// ready flag that doubles as the RxRdy interrupt request.
//
// Ports
//   C        in   clock, all state updates on the rising edge
//   R        in   synchronous active-high reset
//   Rx       in   asynchronous serial line, idle high
//   RdStb    in   one-cycle pulse on a CPU read of the data register
//   RxData   out  [7:0] last correctly framed byte
//   RxRdy    out  unread byte available
//   FrameErr out  last frame had a low stop bit
//   Overrun  out  a byte was replaced before it was read
//
// Parameter
//   DIV      clock cycles per bit (>= 4); half-bit interval is DIV/2
// -----------------------------------------------------------------------------
module uart_rx_unit #(
  parameter int DIV = 5208
) (
  input  logic       C,
  input  logic       R,
  input  logic       Rx,
  input  logic       RdStb,
  output logic [7:0] RxData,
  output logic       RxRdy,
  output logic       FrameErr,
  output logic       Overrun
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            rdy_q, rdy_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            prev_q, prev_d;

  logic            rx_s;
  logic            expire;

  assign rx_s   = sync2_q;
  assign expire = (cnt_q == '0);

  always_ff @(posedge C) begin
    if (R) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    rdy_d   = rdy_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    sync1_d = Rx;
    sync2_d = sync1_q;
    prev_d  = sync2_q;

    // A read acknowledges everything; a stop-bit decision below may override.
    if (RdStb) begin
      rdy_d  = 1'b0;
      ovr_d  = 1'b0;
      ferr_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // Edge, not level: a line stuck low must not start a new frame.
        if (prev_q && !rx_s) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (!expire) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!rx_s) begin
          state_d = DATA;
          cnt_d   = BIT_LOAD;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!expire) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = BIT_LOAD;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (!expire) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = IDLE;
          if (rx_s) begin
            // A good load beats a simultaneous read: the new byte stays unread.
            data_d = shift_q;
            rdy_d  = 1'b1;
            ferr_d = 1'b0;
            ovr_d  = RdStb ? 1'b0 : (ovr_q | rdy_q);
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign RxData   = data_q;
  assign RxRdy    = rdy_q;
  assign FrameErr = ferr_q;
  assign Overrun  = ovr_q;

endmodule

// File: doc/uart_rx_unit.md
# uart_rx_unit

Serial receive front-end for the memory-mapped UART peripheral of the 32-bit single-cycle CPU. It oversamples the asynchronous `Rx` pin, decodes 8N1 frames LSB first, and holds the received byte with a ready flag. The RAM/peripheral decoder consumes that flag as the `RxRdy` interrupt source and as the readable status bit. A CPU load from the data register pulses `RdStb`, which acknowledges the byte.

## Interface
- `DIV`, 5208, clock cycles per bit (50 MHz / 9600 baud). Legal range ≥ 4. Half-bit interval = `DIV/2` (integer division).
- `C`  in  1  clock; all state updates on rising edge.
- `R`  in  1  reset; synchronous, active-high.
- `Rx`  in  1  asynchronous serial line; idle high.
- `RdStb`  in  1  one-cycle pulse when the CPU reads the receive data register.
- `RxData`  out  8  last correctly framed byte.
- `RxRdy`  out  1  unread byte available; interrupt request.
- `FrameErr`  out  1  last frame had stop bit = 0.
- `Overrun`  out  1  a byte was overwritten before it was read.

## Operation
- **Input synchronizer:** two flops on `Rx`, both reset to 1. A third flop holds the previous synchronized value for edge detection. Only the synchronized value `rx_s` is used internally.
- **Counter:** bit counter of `clog2(DIV)` bits; index counter of 3 bits; shift register of 8 bits.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE → START:** on a falling edge of `rx_s` (previous = 1, current = 0). Load counter = `DIV/2 - 1`.
    - A line held low (break, or after a framing error) does not retrigger. A new frame needs a 1→0 transition.
  - **START:**
    - Counter decrements to 0, then `rx_s` is sampled.
    - If the sample is 0: go to DATA, counter = `DIV-1`, index = 0.
    - If the sample is 1: false start; go to IDLE, and no output changes.
  - **DATA:**
    - At each counter expiry, sample `rx_s` into shift[7] and shift right, so the byte is assembled LSB first. Reload counter = `DIV-1`.
    - After the 8th sample (index = 7), go to STOP.
  - **STOP:** at counter expiry, sample `rx_s`, then go to IDLE.
    - If the sample is 1: `RxData` ← shift; `RxRdy` ← 1; `FrameErr` ← 0.
    - If the sample is 0: `FrameErr` ← 1; `RxData` and `RxRdy` are unchanged.
- **Overrun:** on a good stop sample while `RxRdy` = 1 and `RdStb` = 0, set `Overrun` ← 1. The new byte still replaces `RxData`.
- **`RdStb`:** clears `RxRdy`, `Overrun` and `FrameErr` on the next edge.
- **Simultaneous good load and `RdStb`:** the load wins. `RxRdy` stays 1, `Overrun` is not set, `FrameErr` = 0.
- **Simultaneous framing error and `RdStb`:** `RxRdy` and `Overrun` clear; `FrameErr` = 1.
- **Reset (any state, including mid-frame):** FSM → IDLE; counters = 0; shift = 0; sync flops = 1; `RxData` = 0x00; `RxRdy` = 0; `FrameErr` = 0; `Overrun` = 0. The partial frame is discarded.

## Timing
- Let t0 be the cycle in which `rx_s` is first seen low in IDLE. `Rx` went low 2 cycles earlier because of the synchronizer.
- Start bit sample: t0 + `DIV/2`.
- Data bit k (k = 0..7) sample: t0 + `DIV/2` + (k+1)·`DIV`.
- Stop bit sample: t0 + `DIV/2` + 9·`DIV`.
  - `RxData`, `RxRdy` and `FrameErr` are registered at that edge and visible from the following cycle.
- Total latency from the `Rx` falling edge to `RxRdy` high: 2 + `DIV/2` + 9·`DIV` + 1 cycles.
- Earliest next start detection: the cycle after the stop sample. Back-to-back frames with a full-length stop bit are accepted.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
All scenarios use `DIV` = 16 and an ideal bit period of 16 cycles.
- **Basic byte:** drive frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1).
  - Required: `RxData` = 0xA5 and `RxRdy` = 1 exactly 2+8+144+1 = 155 cycles after the `Rx` falling edge; `FrameErr` = 0; `Overrun` = 0.
  - Then pulse `RdStb`: `RxRdy` = 0 on the next cycle.
- **False start:** a low glitch on `Rx` for 4 cycles, then idle.
  - Required: FSM returns to IDLE; `RxRdy`, `RxData` and all flags are unchanged.
  - A 0x3C frame sent afterwards is received correctly.
- **Framing error:** after receiving 0x11, send 0x3C with stop bit 0, then hold the line low for 40 cycles before releasing it.
  - Required: `FrameErr` = 1; `RxData` = 0x11; no retrigger while the line is low.
  - The next valid frame 0x77 gives `RxData` = 0x77, `FrameErr` = 0.
- **Overrun:** send 0x11 then 0x22 back-to-back with no `RdStb`.
  - Required: `RxData` = 0x22, `RxRdy` = 1, `Overrun` = 1.
  - `RdStb` then clears `RxRdy` and `Overrun`.
- **Read/load collision:** assert `RdStb` in the same cycle as the stop sample of the second byte, with `RxRdy` = 1.
  - Required: `RxRdy` stays 1; `Overrun` = 0; `RxData` = new byte.
- **Reset mid-frame:** assert `R` for 1 cycle during DATA bit 4 of 0xFF.
  - Required: all outputs = 0 on the next cycle; the remainder of the frame does not produce `RxRdy`.
  - The following frame 0x5A gives `RxData` = 0x5A.
